ula_mp_sequencer: RTL and testbench

ULA_MP_SEQUENCER -- requirements
Module: ula_mp_sequencer

---
 rtl/ula_pkg.sv | 13 +
 rtl/ula_8_bits_enhanced.sv | 64 ++++++
 rtl/ula_mp_sequencer.sv | 138 +++++++++++++
 tb/tb_ula_mp_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared sequencer state type and ALU op encodings
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;

endpackage

// File: rtl/ula_8_bits_enhanced.sv
// rtl/ula_8_bits_enhanced.sv - 8-bit ALU slice, 181-style select/mode, active-low carries
module ula_8_bits_enhanced
  import ula_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [3:0] i_s,
  input  logic       i_m,
  input  logic       i_c_in,
  output logic [7:0] o_f,
  output logic       o_c_out,
  output logic       o_ovf,
  output logic       o_a_eq_b
);

  logic [8:0] w_sum;
  logic [7:0] w_f;
  logic       w_c_out;
  logic       w_ovf;

  // Carry pins are active-low: i_c_in=0 injects +1, o_c_out=0 reports a carry.
  always_comb begin
    w_sum   = 9'd0;
    w_f     = 8'h00;
    w_c_out = 1'b1;
    w_ovf   = 1'b0;
    if (i_m) begin
      case (i_s)
        4'b0000: w_f = ~i_a;
        4'b0001: w_f = ~(i_a | i_b);
        4'b0010: w_f = ~i_a & i_b;
        4'b0011: w_f = 8'h00;
        4'b0100: w_f = ~(i_a & i_b);
        4'b0101: w_f = ~i_b;
        4'b0110: w_f = i_a ^ i_b;
        4'b0111: w_f = i_a & ~i_b;
        4'b1000: w_f = ~i_a | i_b;
        4'b1001: w_f = ~(i_a ^ i_b);
        4'b1010: w_f = i_b;
        4'b1011: w_f = i_a & i_b;
        4'b1100: w_f = 8'hFF;
        4'b1101: w_f = i_a | ~i_b;
        4'b1110: w_f = i_a | i_b;
        default: w_f = i_a;
      endcase
    end else if (i_s == S_ADD) begin
      w_sum   = {1'b0, i_a} + {1'b0, i_b} + {8'd0, ~i_c_in};
      w_f     = w_sum[7:0];
      w_c_out = ~w_sum[8];
      w_ovf   = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
    end else if (i_s == S_SUB) begin
      w_sum   = {1'b0, i_a} + {1'b0, ~i_b} + {8'd0, ~i_c_in};
      w_f     = w_sum[7:0];
      w_c_out = ~w_sum[8];
      w_ovf   = (i_a[7] != i_b[7]) && (w_sum[7] != i_a[7]);
    end
  end

  assign o_f      = w_f;
  assign o_c_out  = w_c_out;
  assign o_ovf    = w_ovf;
  assign o_a_eq_b = (i_a == i_b);

endmodule

// File: rtl/ula_mp_sequencer.sv
// rtl/ula_mp_sequencer.sv - multi-byte ALU op sequenced one byte per cycle through a single 8-bit slice
module ula_mp_sequencer
  import ula_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  input  logic [3:0]          in_s,
  input  logic                in_m,
  input  logic                in_c_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_f,
  output logic                out_c_out,
  output logic                out_ovf,
  output logic                out_a_eq_b,
  output logic                out_err
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [3:0]      r_s;
  logic            r_m;
  logic            r_c_in;
  logic            r_carry;
  logic            r_eq;
  logic [W-1:0]    r_f;
  logic            r_c_out;
  logic            r_ovf;
  logic            r_a_eq_b;
  logic            r_err;

  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic            w_cin;
  logic [7:0]      w_f;
  logic            w_c_out;
  logic            w_ovf;
  logic            w_eq;
  logic            w_supported;
  logic            w_last;

  assign w_a_byte    = r_a[{r_k, 3'b000} +: 8];
  assign w_b_byte    = r_b[{r_k, 3'b000} +: 8];
  assign w_cin       = (r_k == '0) ? r_c_in : r_carry;
  assign w_supported = in_m | (in_s == S_ADD) | (in_s == S_SUB);
  assign w_last      = (r_k == KW'(NBYTES - 1));

  ula_8_bits_enhanced u_alu (
    .i_a      (w_a_byte),
    .i_b      (w_b_byte),
    .i_s      (r_s),
    .i_m      (r_m),
    .i_c_in   (w_cin),
    .o_f      (w_f),
    .o_c_out  (w_c_out),
    .o_ovf    (w_ovf),
    .o_a_eq_b (w_eq)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= 4'd0;
      r_m      <= 1'b0;
      r_c_in   <= 1'b1;
      r_carry  <= 1'b1;
      r_eq     <= 1'b0;
      r_f      <= '0;
      r_c_out  <= 1'b1;
      r_ovf    <= 1'b0;
      r_a_eq_b <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Result registers are preset here so an unsupported op leaves them at the error values.
          if (in_valid) begin
            r_a      <= in_a;
            r_b      <= in_b;
            r_s      <= in_s;
            r_m      <= in_m;
            r_c_in   <= in_c_in;
            r_k      <= '0;
            r_eq     <= 1'b1;
            r_f      <= '0;
            r_c_out  <= 1'b1;
            r_ovf    <= 1'b0;
            r_a_eq_b <= 1'b0;
            r_err    <= ~w_supported;
            r_state  <= w_supported ? RUN : DONE;
          end
        end
        RUN: begin
          r_f[{r_k, 3'b000} +: 8] <= w_f;
          r_eq    <= r_eq & w_eq;
          r_carry <= w_c_out;
          if (w_last) begin
            r_c_out  <= w_c_out;
            r_ovf    <= r_m ? 1'b0 : w_ovf;
            r_a_eq_b <= r_eq & w_eq;
            r_state  <= DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign out_f      = r_f;
  assign out_c_out  = r_c_out;
  assign out_ovf    = r_ovf;
  assign out_a_eq_b = r_a_eq_b;
  assign out_err    = r_err;

endmodule

// File: tb/tb_ula_mp_sequencer.sv
// tb/tb_ula_mp_sequencer.sv - directed self-checking bench for ula_mp_sequencer
module tb_ula_mp_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_s;
  logic        in_m;
  logic        in_c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;
  logic        out_c_out;
  logic        out_ovf;
  logic        out_a_eq_b;
  logic        out_err;

  int n_vec;
  int n_bad;

  ula_mp_sequencer #(.NBYTES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_s       (in_s),
    .in_m       (in_m),
    .in_c_in    (in_c_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_c_out  (out_c_out),
    .out_ovf    (out_ovf),
    .out_a_eq_b (out_a_eq_b),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and returns the number of edges from accept until out_valid (20 = timeout).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                       input logic m, input logic cin, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_s = s; in_m = m; in_c_in = cin; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_f, out_c_out, out_ovf, out_a_eq_b, out_err} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset got rdy=%b vld=%b f=%h c=%b ovf=%b eq=%b err=%b exp rdy=1 vld=0 f=0 c=1 ovf=0 eq=0 err=0",
               in_ready, out_valid, out_f, out_c_out, out_ovf, out_a_eq_b, out_err);
    end
  endtask

  task automatic test_add;
    logic [31:0] va [3] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] vb [3] = '{32'h00000001, 32'h00000001, 32'h00000001};
    logic [31:0] ef [3] = '{32'h00000100, 32'h00000000, 32'h80000000};
    logic        ec [3] = '{1'b1, 1'b0, 1'b1};
    logic        eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 4'b1001, 1'b0, 1'b1, lat);
      n_vec++;
      if (lat !== 5) begin n_bad++; $display("FAIL add_latency[%0d] got %0d exp 5", i, lat); end
      n_vec++;
      if ({out_f, out_c_out, out_ovf, out_err, out_a_eq_b} !== {ef[i], ec[i], eo[i], 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL add[%0d] got f=%h c=%b ovf=%b err=%b eq=%b exp f=%h c=%b ovf=%b err=0 eq=0",
                 i, out_f, out_c_out, out_ovf, out_err, out_a_eq_b, ef[i], ec[i], eo[i]);
      end
      consume();
    end
  endtask

  task automatic test_sub;
    int lat;
    do_op(32'h00010000, 32'h00000001, 4'b0110, 1'b0, 1'b0, lat);
    n_vec++;
    if ({out_f, out_c_out, out_ovf, out_a_eq_b} !== {32'h0000FFFF, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL sub_borrow got f=%h c=%b ovf=%b eq=%b exp f=0000ffff c=0 ovf=0 eq=0", out_f, out_c_out, out_ovf, out_a_eq_b);
    end
    consume();
    do_op(32'h12345678, 32'h12345678, 4'b0110, 1'b0, 1'b1, lat);
    n_vec++;
    if ({out_f, out_c_out, out_ovf, out_a_eq_b, lat} !== {32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'd5}) begin
      n_bad++;
      $display("FAIL sub_equal got f=%h c=%b ovf=%b eq=%b lat=%0d exp f=ffffffff c=1 ovf=0 eq=1 lat=5", out_f, out_c_out, out_ovf, out_a_eq_b, lat);
    end
    consume();
  endtask

  task automatic test_logic;
    logic [3:0]  vs [3] = '{4'b0110, 4'b1011, 4'b0000};
    logic [31:0] ef [3] = '{32'h0FF00FF0, 32'hF000F000, 32'h0F0F0F0F};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(32'hF0F0F0F0, 32'hFF00FF00, vs[i], 1'b1, 1'b0, lat);
      n_vec++;
      if ({out_f, out_ovf, out_err, lat} !== {ef[i], 1'b0, 1'b0, 32'd5}) begin
        n_bad++;
        $display("FAIL logic[%0d] got f=%h ovf=%b err=%b lat=%0d exp f=%h ovf=0 err=0 lat=5", i, out_f, out_ovf, out_err, lat, ef[i]);
      end
      consume();
    end
  endtask

  task automatic test_unsupported;
    int lat;
    do_op(32'h11111111, 32'h22222222, 4'b0000, 1'b0, 1'b1, lat);
    n_vec++;
    if ({out_err, out_f, out_c_out, out_ovf, out_a_eq_b, lat} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'd1}) begin
      n_bad++;
      $display("FAIL unsupported got err=%b f=%h c=%b ovf=%b eq=%b lat=%0d exp err=1 f=0 c=1 ovf=0 eq=0 lat=1",
               out_err, out_f, out_c_out, out_ovf, out_a_eq_b, lat);
    end
    consume();
    n_vec++;
    if ({in_ready, out_valid, out_err} !== 3'b101) begin
      n_bad++;
      $display("FAIL unsupported_idle got rdy=%b vld=%b err=%b exp rdy=1 vld=0 err=1", in_ready, out_valid, out_err);
    end
    do_op(32'h00000002, 32'h00000003, 4'b1001, 1'b0, 1'b1, lat);
    n_vec++;
    if ({out_err, out_f} !== {1'b0, 32'h00000005}) begin
      n_bad++;
      $display("FAIL err_clear got err=%b f=%h exp err=0 f=00000005", out_err, out_f);
    end
    consume();
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    do_op(32'h00000001, 32'h00000002, 4'b1001, 1'b0, 1'b1, lat);
    @(negedge clk);
    in_a = 32'hAAAAAAAA; in_b = 32'h55555555; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if ({out_valid, in_ready, out_f, out_c_out, out_ovf} !== {1'b1, 1'b0, 32'h00000003, 1'b1, 1'b0}) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL backpressure_hold got %0d unstable cycles, last vld=%b rdy=%b f=%h exp 0", bad, out_valid, in_ready, out_f);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_vec++;
    if ({in_ready, out_valid, out_f} !== {1'b1, 1'b0, 32'h00000003}) begin
      n_bad++;
      $display("FAIL backpressure_release got rdy=%b vld=%b f=%h exp rdy=1 vld=0 f=00000003", in_ready, out_valid, out_f);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL no_queue got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int seen;
    @(negedge clk);
    in_a = 32'hFFFFFFFF; in_b = 32'h00000001; in_s = 4'b1001; in_m = 1'b0; in_c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL reset_mid_run got %0d cycles busy/valid exp 0", seen);
    end
    do_op(32'h01020304, 32'h10203040, 4'b1001, 1'b0, 1'b1, lat);
    n_vec++;
    if ({out_f, out_c_out, lat} !== {32'h11223344, 1'b1, 32'd5}) begin
      n_bad++;
      $display("FAIL after_reset_op got f=%h c=%b lat=%0d exp f=11223344 c=1 lat=5", out_f, out_c_out, lat);
    end
    consume();
  endtask

  task automatic test_back_to_back;
    int lat;
    do_op(32'h80000000, 32'h80000000, 4'b1001, 1'b0, 1'b1, lat);
    n_vec++;
    if ({out_f, out_c_out, out_ovf, in_ready} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL b2b_first got f=%h c=%b ovf=%b rdy=%b exp f=0 c=0 ovf=1 rdy=0", out_f, out_c_out, out_ovf, in_ready);
    end
    consume();
    do_op(32'h0000FFFF, 32'h00000001, 4'b0110, 1'b0, 1'b1, lat);
    n_vec++;
    if ({out_f, out_c_out, out_ovf, lat} !== {32'h0000FFFD, 1'b0, 1'b0, 32'd5}) begin
      n_bad++;
      $display("FAIL b2b_second got f=%h c=%b ovf=%b lat=%0d exp f=0000fffd c=0 ovf=0 lat=5", out_f, out_c_out, out_ovf, lat);
    end
    consume();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_s = 4'd0;
    in_m = 1'b0;
    in_c_in = 1'b1;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_unsupported();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
